// File: rtl/cpu_selfcheck.sv
// rtl/cpu_selfcheck.sv - register-file expectation checker with optional polling
module cpu_selfcheck #(
  parameter int NUM_CHECKS     = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int WAIT_CYCLES    = 20,
  parameter int POLL_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_CHECKS-1:0]          chk_en,
  input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
  output logic [ADDR_W-1:0]              rf_raddr,
  input  logic [DATA_W-1:0]              rf_rdata,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [NUM_CHECKS-1:0]          fail_mask,
  output logic [$clog2(NUM_CHECKS):0]    fail_idx,
  output logic [DATA_W-1:0]              fail_data,
  output logic                           timeout
);

  localparam int IW = $clog2(NUM_CHECKS) + 1;
  localparam int WW = $clog2(WAIT_CYCLES + 1) + 1;
  localparam int EW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHECKS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [EW-1:0] TO_LIM    = EW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SCAN, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [EW-1:0]           elapsed_q, elapsed_d, elapsed_inc;
  logic [NUM_CHECKS-1:0]   shadow_mask_q, shadow_mask_d;
  logic [IW-1:0]           shadow_idx_q, shadow_idx_d;
  logic [DATA_W-1:0]       shadow_data_q, shadow_data_d;
  logic [NUM_CHECKS-1:0]   fail_mask_q, fail_mask_d;
  logic [IW-1:0]           fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0]       fail_data_q, fail_data_d;
  logic                    timeout_q, timeout_d;

  logic                    cur_en;
  logic [ADDR_W-1:0]       cur_addr;
  logic [DATA_W-1:0]       cur_data;
  logic [NUM_CHECKS-1:0]   hit;
  logic                    mismatch;
  logic [NUM_CHECKS-1:0]   base_mask, new_mask;
  logic [IW-1:0]           base_idx, new_idx;
  logic [DATA_W-1:0]       base_data, new_data;

  // Select the channel currently being scanned (one-hot compare avoids a variable bit index)
  always_comb begin
    cur_en   = 1'b0;
    cur_addr = '0;
    cur_data = '0;
    hit      = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_en   = chk_en[i];
        cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
        cur_data = exp_data[i*DATA_W +: DATA_W];
        hit[i]   = 1'b1;
      end
    end
  end

  // Next-state logic: sequencing, per-sweep shadow accumulation and result publication
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    elapsed_d     = elapsed_q;
    shadow_mask_d = shadow_mask_q;
    shadow_idx_d  = shadow_idx_q;
    shadow_data_d = shadow_data_q;
    fail_mask_d   = fail_mask_q;
    fail_idx_d    = fail_idx_q;
    fail_data_d   = fail_data_q;
    timeout_d     = timeout_q;

    mismatch  = cur_en && (rf_rdata != cur_data);
    // Index 0 starts a fresh sweep, so earlier sweep results are discarded here
    base_mask = (idx_q == '0) ? '0 : shadow_mask_q;
    base_idx  = (idx_q == '0) ? '0 : shadow_idx_q;
    base_data = (idx_q == '0) ? '0 : shadow_data_q;
    new_mask  = base_mask | (mismatch ? hit : '0);
    new_idx   = base_idx;
    new_data  = base_data;
    // Channels are visited in ascending order, so the first capture is the lowest index
    if (mismatch && (base_mask == '0)) begin
      new_idx  = idx_q;
      new_data = rf_rdata;
    end
    elapsed_inc = (elapsed_q >= TO_LIM) ? elapsed_q : elapsed_q + EW'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = (WAIT_CYCLES == 0) ? ST_SCAN : ST_WAIT;
          idx_d         = '0;
          wait_d        = '0;
          elapsed_d     = '0;
          shadow_mask_d = '0;
          shadow_idx_d  = '0;
          shadow_data_d = '0;
          fail_mask_d   = '0;
          fail_idx_d    = '0;
          fail_data_d   = '0;
          timeout_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_SCAN: begin
        elapsed_d     = elapsed_inc;
        shadow_mask_d = new_mask;
        shadow_idx_d  = new_idx;
        shadow_data_d = new_data;
        if (idx_q == LAST_IDX) begin
          fail_mask_d = new_mask;
          fail_idx_d  = new_idx;
          fail_data_d = new_data;
          idx_d       = '0;
          if ((POLL_MODE == 0) || (new_mask == '0)) begin
            state_d = ST_DONE;
          end else if (elapsed_inc >= TO_LIM) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      elapsed_q     <= '0;
      shadow_mask_q <= '0;
      shadow_idx_q  <= '0;
      shadow_data_q <= '0;
      fail_mask_q   <= '0;
      fail_idx_q    <= '0;
      fail_data_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      elapsed_q     <= elapsed_d;
      shadow_mask_q <= shadow_mask_d;
      shadow_idx_q  <= shadow_idx_d;
      shadow_data_q <= shadow_data_d;
      fail_mask_q   <= fail_mask_d;
      fail_idx_q    <= fail_idx_d;
      fail_data_q   <= fail_data_d;
      timeout_q     <= timeout_d;
    end
  end

  assign rf_raddr  = (state_q == ST_SCAN) ? cur_addr : '0;
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_SCAN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (fail_mask_q == '0) && !timeout_q;
  assign fail_mask = fail_mask_q;
  assign fail_idx  = fail_idx_q;
  assign fail_data = fail_data_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_selfcheck.sv
// tb/tb_cpu_selfcheck.sv - scoreboard bench for cpu_selfcheck (single-sweep and poll instances)
module tb_cpu_selfcheck;

  typedef struct packed {
    logic [15:0] edge_n;
    logic        pass;
    logic        to;
    logic [3:0]  mask;
    logic [2:0]  idx;
    logic [31:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  res_t sb[$];

  logic        start_a, start_b;
  logic [3:0]  en_a, en_b;
  logic [19:0] addr_a, addr_b;
  logic [127:0] data_a, data_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [3:0]  mask_a, mask_b;
  logic [2:0]  idx_a, idx_b;
  logic [31:0] fdata_a, fdata_b;
  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];

  assign rdata_a = rf_a[raddr_a];
  assign rdata_b = rf_b[raddr_b];

  always #5 clk = ~clk;

  cpu_selfcheck u_single (
    .clk(clk), .rst_n(rst_n), .start(start_a), .chk_en(en_a),
    .exp_addr(addr_a), .exp_data(data_a), .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(mask_a),
    .fail_idx(idx_a), .fail_data(fdata_a), .timeout(timeout_a)
  );

  cpu_selfcheck #(.POLL_MODE(1), .TIMEOUT_CYCLES(40)) u_poll (
    .clk(clk), .rst_n(rst_n), .start(start_b), .chk_en(en_b),
    .exp_addr(addr_b), .exp_data(data_b), .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(mask_b),
    .fail_idx(idx_b), .fail_data(fdata_b), .timeout(timeout_b)
  );

  function automatic res_t obs_a(input int e);
    res_t r;
    r.edge_n = 16'(e); r.pass = pass_a; r.to = timeout_a;
    r.mask = mask_a; r.idx = idx_a; r.data = fdata_a;
    return r;
  endfunction

  function automatic res_t obs_b(input int e);
    res_t r;
    r.edge_n = 16'(e); r.pass = pass_b; r.to = timeout_b;
    r.mask = mask_b; r.idx = idx_b; r.data = fdata_b;
    return r;
  endfunction

  // Reference result for a single sweep of u_single, from the bench's own register file
  function automatic res_t model_a();
    res_t r;
    r = '0;
    r.edge_n = 16'd24;
    for (int i = 0; i < 4; i++) begin
      if (en_a[i] && (rf_a[addr_a[i*5 +: 5]] !== data_a[i*32 +: 32])) begin
        if (r.mask == 4'b0) begin
          r.idx  = 3'(i);
          r.data = rf_a[addr_a[i*5 +: 5]];
        end
        r.mask[i] = 1'b1;
      end
    end
    r.pass = (r.mask == 4'b0);
    return r;
  endfunction

  task automatic set_ch_a(input int ch, input logic [4:0] a, input logic [31:0] d);
    addr_a[ch*5 +: 5]  = a;
    data_a[ch*32 +: 32] = d;
  endtask

  task automatic clear_cfg_a();
    en_a = '0; addr_a = '0; data_a = '0;
    for (int i = 0; i < 32; i++) rf_a[i] = '0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
  endtask

  // Returns the start-relative edge after which done was first seen, or -1 on expiry
  task automatic wait_done_a(output int e);
    e = -1;
    for (int k = 0; k < 200; k++) begin
      if (done_a) begin e = k; break; end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic wait_done_b(input int poke_edge, output int e);
    e = -1;
    for (int k = 0; k < 300; k++) begin
      if (k == poke_edge) rf_b[2] = 32'd10;
      if (done_b) begin e = k; break; end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [71:0] o;
    repeat (2) @(negedge clk);
    o = {busy_a, done_a, pass_a, timeout_a, mask_a, idx_a, fdata_a, raddr_a,
         busy_b, done_b, pass_b, timeout_b, mask_b, idx_b};
    checks++;
    if (o !== '0 || fdata_b !== '0 || raddr_b !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%h required all zero", o, fdata_b, raddr_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    int e; res_t got, ex;
    clear_cfg_a();
    rf_a[2] = 32'd10; set_ch_a(0, 5'd2, 32'd10); en_a = 4'b0001;
    ex = '0; ex.edge_n = 16'd24; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_a();
    checks++;
    if (busy_a !== 1'b1 || raddr_a !== 5'd0) begin
      failures++;
      $display("FAIL wait_busy got busy=%b raddr=%0d required busy=1 raddr=0", busy_a, raddr_a);
    end
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL single_pass got=%h required=%h", got, ex);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done got=%b required=0", busy_a);
    end
  endtask

  task automatic test_single_fail();
    int e; res_t got, ex;
    clear_cfg_a();
    rf_a[2] = 32'd7; set_ch_a(0, 5'd2, 32'd10); en_a = 4'b0001;
    ex = '0; ex.edge_n = 16'd24; ex.mask = 4'b0001; ex.data = 32'd7;
    sb.push_back(ex);
    pulse_start_a();
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL single_fail got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_enable_mask();
    int e; res_t got, ex;
    clear_cfg_a();
    set_ch_a(0, 5'd2, 32'd99);  rf_a[2] = 32'd1;
    set_ch_a(1, 5'd3, 32'd5);   rf_a[3] = 32'd5;
    set_ch_a(2, 5'd4, 32'd123); rf_a[4] = 32'd0;
    set_ch_a(3, 5'd9, 32'd1);   rf_a[9] = 32'd0;
    en_a = 4'b1010;
    ex = '0; ex.edge_n = 16'd24; ex.mask = 4'b1000; ex.idx = 3'd3; ex.data = 32'd0;
    sb.push_back(ex);
    pulse_start_a();
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL enable_mask got=%h required=%h", got, ex);
    end
    // All enabled: ch0, ch2, ch3 fail; lowest is ch0 whose register holds 1
    en_a = 4'b1111;
    ex = '0; ex.edge_n = 16'd24; ex.mask = 4'b1101; ex.idx = 3'd0; ex.data = 32'd1;
    sb.push_back(ex);
    pulse_start_a();
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL multi_fail got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_all_disabled();
    int e; res_t got, ex;
    en_a = 4'b0000;
    ex = '0; ex.edge_n = 16'd24; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_a();
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL all_disabled got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_back_to_back();
    int e; res_t got, ex;
    clear_cfg_a();
    rf_a[2] = 32'd7; set_ch_a(0, 5'd2, 32'd10); en_a = 4'b0001;
    pulse_start_a();
    wait_done_a(e);
    rf_a[2] = 32'd10;
    ex = '0; ex.edge_n = 16'd24; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_a();
    checks++;
    if (mask_a !== 4'b0 || fdata_a !== 32'd0 || done_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear got mask=%b data=%0d done=%b busy=%b required 0/0/0/1",
               mask_a, fdata_a, done_a, busy_a);
    end
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL back_to_back got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_random();
    int e; res_t got, ex;
    for (int n = 0; n < 5; n++) begin
      clear_cfg_a();
      en_a = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) begin
        logic [4:0] a; logic [31:0] d;
        a = 5'($urandom_range(1, 31));
        d = $urandom;
        set_ch_a(c, a, d);
        rf_a[a] = ($urandom_range(0, 1) == 1) ? d : (d ^ 32'h0000_0100);
      end
      ex = model_a();
      sb.push_back(ex);
      pulse_start_a();
      wait_done_a(e);
      got = obs_a(e); ex = sb.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL random_%0d got=%h required=%h", n, got, ex);
      end
    end
  endtask

  task automatic test_start_ignored();
    int e; res_t got, ex;
    clear_cfg_a();
    rf_a[2] = 32'd10; set_ch_a(0, 5'd2, 32'd10); en_a = 4'b0001;
    ex = '0; ex.edge_n = 16'd24; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_a();
    e = -1;
    for (int k = 0; k < 200; k++) begin
      start_a = (k == 5 || k == 21);
      if (done_a) begin e = k; break; end
      @(posedge clk); @(negedge clk);
    end
    start_a = 1'b0;
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL start_ignored got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_reset_mid_scan();
    int e; res_t got, ex;
    logic [42:0] o;
    clear_cfg_a();
    rf_a[2] = 32'd10; set_ch_a(0, 5'd2, 32'd10); set_ch_a(1, 5'd6, 32'd0); en_a = 4'b0001;
    pulse_start_a();
    repeat (20) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (raddr_a !== 5'd2) begin
      failures++;
      $display("FAIL scan_raddr got=%0d required=2", raddr_a);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    o = {busy_a, done_a, pass_a, timeout_a, mask_a, idx_a, fdata_a};
    checks++;
    if (o !== '0 || raddr_a !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_scan got=%h raddr=%0d required zero", o, raddr_a);
    end
    @(negedge clk); rst_n = 1'b1;
    ex = '0; ex.edge_n = 16'd24; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_a();
    wait_done_a(e);
    got = obs_a(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL rerun_after_reset got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_poll_pass();
    int e; res_t got, ex;
    for (int i = 0; i < 32; i++) rf_b[i] = '0;
    en_b = 4'b0001; addr_b = 20'd2; data_b = 128'd10;
    // Sweeps start at edges 20,24,28,32; the write after edge 30 is first seen by the sweep at 32
    ex = '0; ex.edge_n = 16'd36; ex.pass = 1'b1;
    sb.push_back(ex);
    pulse_start_b();
    wait_done_b(30, e);
    got = obs_b(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL poll_pass got=%h required=%h", got, ex);
    end
  endtask

  task automatic test_poll_timeout();
    int e; res_t got, ex;
    for (int i = 0; i < 32; i++) rf_b[i] = '0;
    // Forty scan cycles have elapsed at the sweep boundary on edge 60
    ex = '0; ex.edge_n = 16'd60; ex.to = 1'b1; ex.mask = 4'b0001; ex.data = 32'd0;
    sb.push_back(ex);
    pulse_start_b();
    wait_done_b(-1, e);
    got = obs_b(e); ex = sb.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL poll_timeout got=%h required=%h", got, ex);
    end
  endtask

  initial begin
    start_a = 1'b0; start_b = 1'b0;
    en_a = '0; addr_a = '0; data_a = '0;
    en_b = '0; addr_b = '0; data_b = '0;
    for (int i = 0; i < 32; i++) begin rf_a[i] = '0; rf_b[i] = '0; end
    test_reset();
    test_single_pass();
    test_single_fail();
    test_enable_mask();
    test_all_disabled();
    test_back_to_back();
    test_random();
    test_start_ignored();
    test_reset_mid_scan();
    test_poll_pass();
    test_poll_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_selfcheck.md
CPU_SELFCHECK -- requirements
Module: cpu_selfcheck

Interface
REQ-001 Parameter NUM_CHECKS, default 4, number of register-expectation channels (1..16).
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 5, register-file address width.
REQ-004 Parameter WAIT_CYCLES, default 20, settle cycles after start before first sweep (0 allowed).
REQ-005 Parameter POLL_MODE, default 0; 0 = single sweep, 1 = repeat sweeps until all match or timeout.
REQ-006 Parameter TIMEOUT_CYCLES, default 1000, poll-mode limit in cycles counted from the first SCAN cycle.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  begin a check run; sampled on rising edge.
REQ-010 chk_en  input  NUM_CHECKS  per-channel enable mask.
REQ-011 exp_addr  input  NUM_CHECKS*ADDR_W  packed register addresses, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-012 exp_data  input  NUM_CHECKS*DATA_W  packed expected values, same packing.
REQ-013 rf_raddr  output  ADDR_W  debug read address into CPU register file.
REQ-014 rf_rdata  input  DATA_W  combinational register-file read data for rf_raddr, same cycle.
REQ-015 busy  output  1  high in WAIT and SCAN.
REQ-016 done  output  1  high in DONE, held until next start or reset.
REQ-017 pass  output  1  valid when done; 1 iff fail_mask == 0 and no timeout.
REQ-018 fail_mask  output  NUM_CHECKS  bit i set if enabled channel i mismatched in the final sweep.
REQ-019 fail_idx  output  $clog2(NUM_CHECKS)+1 bits  lowest failing channel index of final sweep.
REQ-020 fail_data  output  DATA_W  rf_rdata captured for fail_idx.
REQ-021 timeout  output  1  high in DONE when poll mode ended by TIMEOUT_CYCLES.

Function
REQ-022 FSM states IDLE, WAIT, SCAN, DONE; exactly one active.
REQ-023 IDLE or DONE, start=1 -> WAIT (SCAN directly if WAIT_CYCLES=0); clears fail_mask, fail_idx, fail_data, timeout, cycle counters.
REQ-024 start while busy ignored, no effect on state or counters.
REQ-025 WAIT lasts exactly WAIT_CYCLES cycles, then SCAN with channel index 0.
REQ-026 SCAN visits one channel per cycle, index 0..NUM_CHECKS-1; rf_raddr = exp_addr[index]; compare rf_rdata to exp_data[index] same cycle, result registered.
REQ-027 Disabled channel still consumes its SCAN cycle; never sets fail_mask.
REQ-028 fail_mask/fail_idx/fail_data reflect only the most recent complete sweep; per-sweep shadow cleared at sweep start.
REQ-029 POLL_MODE=0: after last channel -> DONE; single-run latency: start edge counts as edge 0, done high after edge WAIT_CYCLES+NUM_CHECKS.
REQ-030 POLL_MODE=1: end of sweep, no enabled mismatch -> DONE pass; else elapsed >= TIMEOUT_CYCLES -> DONE with timeout=1, pass=0; else restart sweep at index 0 next cycle.
REQ-031 Timeout checked only at sweep boundaries; elapsed counter saturates, no wrap.
REQ-032 chk_en all zero -> DONE after one sweep, pass=1.
REQ-033 rf_raddr = 0 outside SCAN.
REQ-034 fail_idx = 0, fail_data = 0 when fail_mask == 0.
REQ-035 exp_addr/exp_data/chk_en required stable from start to done; changes mid-run use current value in the SCAN cycle.

Reset
REQ-036 rst_n low asynchronously forces IDLE; busy, done, pass, timeout, fail_mask, fail_idx, fail_data, rf_raddr, counters = 0.
REQ-037 Reset mid-WAIT or mid-SCAN aborts run; no done pulse; first start after rst_n high begins clean run.

Verification
REQ-038 Default params, stub regfile r2=10, ch0 addr 2 exp 10, chk_en=0001, start -> done after edge 24, pass=1, fail_mask=0.
REQ-039 Same, r2=7 -> done after edge 24, pass=0, fail_mask=0001, fail_idx=0, fail_data=7.
REQ-040 chk_en=1010, ch1 r3 exp 5 (holds 5), ch3 r9 exp 1 (holds 0) -> fail_mask=1000, fail_idx=3, fail_data=0; ch0/ch2 mismatches ignored.
REQ-041 POLL_MODE=1, TIMEOUT_CYCLES=40, r2 goes 0->10 at cycle 30 -> done pass=1, timeout=0; r2 never 10 -> done timeout=1, pass=0 at first sweep end with elapsed >= 40.
REQ-042 start pulsed again during SCAN -> ignored, done timing unchanged; rst_n low mid-SCAN -> all outputs 0 immediately, new start after release -> REQ-038 result.
